data_mem_responder: RTL and testbench

Word-addressed data memory that answers the processor's MEM-stage load/store requests and stalls the pipeline while a synchronous read is in flight. It also provides a valid/ready dump port that streams the full memory contents out after a program run, so results the processor stored can be read back by a host or display path. The block sits between the EX/MEM pipeline register outputs and the MEM/WB register input (`rdata` feeds `data_out_mem`).

---
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: synchronous single-port RAM serving loads and stores,
// with a pipeline stall while a read is in flight and a valid/ready dump port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accept store / load / pending dump (in that priority)
// RD_WAIT  | RAM output captured into rdata
// RD_DONE  | rdata valid, stall released, held mem_read ignored
// DUMP_RD  | RAM read issued at dump index
// DUMP_OUT | dump word presented, waiting for dump_ready
module data_mem_responder #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic [31:0]   addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          stall,
   output logic          err,
   input  logic          dump_start,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [DW-1:0] dump_data,
   output logic [AW-1:0] dump_addr,
   output logic          dump_busy
);

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DONE,
      DUMP_RD,
      DUMP_OUT
   } state_t;

   state_t        state;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ram_q;
   logic [AW-1:0] idx;
   logic [AW-1:0] dump_idx;
   logic [AW-1:0] ram_addr;
   logic          oor;
   logic          rd_oor;
   logic          pending;
   logic          ram_we;
   logic          in_dump;

   assign idx      = addr[AW-1:0];
   assign oor      = (addr >= 32'(DEPTH));
   assign in_dump  = (state == DUMP_RD) || (state == DUMP_OUT);
   assign ram_we   = (state == IDLE) && mem_write && !oor;
   assign ram_addr = (state == IDLE) ? idx : dump_idx;

   // One shared address port: processor requests in IDLE, dump index otherwise.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= wdata;
      end
      ram_q <= mem[ram_addr];
   end

   assign stall      = ((state == IDLE) && mem_read && !mem_write) ||
                       (state == RD_WAIT) || in_dump;
   assign dump_valid = (state == DUMP_OUT);
   assign dump_data  = dump_valid ? ram_q : '0;
   assign dump_addr  = dump_idx;
   assign dump_busy  = pending || in_dump;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pending  <= 1'b0;
         dump_idx <= '0;
         rdata    <= '0;
         err      <= 1'b0;
         rd_oor   <= 1'b0;
      end else begin
         err <= 1'b0;
         if (dump_start && !in_dump) begin
            pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (mem_write) begin
                  err <= oor || mem_read;
               end else if (mem_read) begin
                  err    <= oor;
                  rd_oor <= oor;
                  state  <= RD_WAIT;
               end else if (pending) begin
                  pending  <= 1'b0;
                  dump_idx <= '0;
                  state    <= DUMP_RD;
               end
            end
            RD_WAIT: begin
               rdata <= rd_oor ? '0 : ram_q;
               state <= RD_DONE;
            end
            RD_DONE: begin
               state <= IDLE;
            end
            DUMP_RD: begin
               state <= DUMP_OUT;
            end
            DUMP_OUT: begin
               if (dump_ready) begin
                  if (dump_idx == AW'(DEPTH - 1)) begin
                     state <= IDLE;
                  end else begin
                     dump_idx <= dump_idx + 1'b1;
                     state    <= DUMP_RD;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of load/store vectors plus dump,
// collision and reset sequences, with queues of expected read and dump words.
module tb_data_mem_responder;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          stall;
   logic          err;
   logic          dump_start;
   logic          dump_valid;
   logic          dump_ready;
   logic [DW-1:0] dump_data;
   logic [AW-1:0] dump_addr;
   logic          dump_busy;

   data_mem_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .stall      (stall),
      .err        (err),
      .dump_start (dump_start),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_data  (dump_data),
      .dump_addr  (dump_addr),
      .dump_busy  (dump_busy)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [DW-1:0] rd_q [$];
   logic [DW-1:0] dd_q [$];
   logic [AW-1:0] da_q [$];

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Called at posedge+1; returns at posedge+1 of the following cycle.
   task automatic op_write(input logic [31:0] a, input logic [31:0] d,
                           input logic rd, input logic exp_err);
      mem_write = 1'b1;
      mem_read  = rd;
      addr      = a;
      wdata     = d;
      @(negedge clk);
      check("wr_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      check("wr_err", 32'(err), 32'(exp_err));
   endtask

   task automatic op_read(input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
      int stall_cycles;
      bit done;
      logic [DW-1:0] e;
      mem_read = 1'b1;
      addr     = a;
      rd_q.push_back(exp);
      @(negedge clk);
      check("rd_stall_c0", 32'(stall), 32'd1);
      @(posedge clk); #1;
      check("rd_err", 32'(err), 32'(exp_err));
      stall_cycles = 1;
      done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            break;
         end
         stall_cycles++;
         @(posedge clk); #1;
      end
      check("rd_latency", 32'(stall_cycles), 32'd2);
      e = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
      if (done) begin
         check("rd_data", rdata, e);
         check("rd_err_end", 32'(err), 32'd0);
      end
      @(posedge clk); #1;
      mem_read = 1'b0;
   endtask

   task automatic push_dump_expect();
      for (int i = 0; i < DEPTH; i++) begin
         dd_q.push_back(32'(i + 100));
         da_q.push_back(AW'(i));
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the last handshake edge.
   task automatic run_dump(input bit toggle, output int hs);
      logic [DW-1:0] pd;
      logic [AW-1:0] pa;
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      bit hold;
      hold = 1'b0;
      hs   = 0;
      pd   = '0;
      pa   = '0;
      for (int c = 0; c < 200 && hs < DEPTH; c++) begin
         dump_ready = toggle ? c[0] : 1'b1;
         @(negedge clk);
         if (dump_valid) begin
            if (hold) begin
               check("dump_data_hold", dump_data, pd);
               check("dump_addr_hold", 32'(dump_addr), 32'(pa));
            end
            pd = dump_data;
            pa = dump_addr;
            if (dump_ready) begin
               hs++;
               hold = 1'b0;
               ed = (dd_q.size() > 0) ? dd_q.pop_front() : 32'hxxxx_xxxx;
               ea = (da_q.size() > 0) ? da_q.pop_front() : 'x;
               check("dump_data", dump_data, ed);
               check("dump_addr", 32'(dump_addr), 32'(ea));
            end else begin
               hold = 1'b1;
            end
         end else begin
            hold = 1'b0;
         end
         @(posedge clk); #1;
      end
      dump_ready = 1'b0;
      check("dump_count", 32'(hs), 32'(DEPTH));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdata"}, rdata, 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_dvalid"}, 32'(dump_valid), 32'd0);
      check({tag, "_ddata"}, dump_data, 32'd0);
      check({tag, "_daddr"}, 32'(dump_addr), 32'd0);
      check({tag, "_dbusy"}, 32'(dump_busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs;
      bit seen;

      vecs[0]  = '{1'b1, 1'b0, 32'd0,    32'hA0A0_A0A0, 32'h0,         1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'd5,    32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'd5,    32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'd1024, 32'h1234,      32'h0,         1'b1};
      vecs[4]  = '{1'b0, 1'b1, 32'd1024, 32'h0,         32'h0,         1'b1};
      vecs[5]  = '{1'b0, 1'b1, 32'd0,    32'h0,         32'hA0A0_A0A0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 32'd7,    32'h55,        32'h0,         1'b1};
      vecs[7]  = '{1'b0, 1'b1, 32'd7,    32'h0,         32'h55,        1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'd15,   32'hFFFF_0000, 32'h0,         1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'd15,   32'h0,         32'hFFFF_0000, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 32'd16,   32'hBAD,       32'h0,         1'b1};
      vecs[11] = '{1'b0, 1'b1, 32'd0,    32'h0,         32'hA0A0_A0A0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 32'd16,   32'h0,         32'h0,         1'b1};

      rst        = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr       = '0;
      wdata      = '0;
      dump_start = 1'b0;
      dump_ready = 1'b0;

      #12;
      check_all_zero("reset");
      mem_read = 1'b1;
      #1;
      check("reset_stall_comb", 32'(stall), 32'd1);
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         if (vecs[i].wr) op_write(vecs[i].a, vecs[i].d, vecs[i].rd, vecs[i].exp_err);
         else            op_read(vecs[i].a, vecs[i].exp_rdata, vecs[i].exp_err);
      end

      // Dump with backpressure
      for (int i = 0; i < DEPTH; i++) op_write(32'(i), 32'(i + 100), 1'b0, 1'b0);
      push_dump_expect();
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      check("dump_busy_pending", 32'(dump_busy), 32'd1);
      run_dump(1'b1, hs);
      check("dump_busy_end", 32'(dump_busy), 32'd0);

      // Collision: read and dump_start together, then a write during the dump
      fork
         op_read(32'd3, 32'd103, 1'b0);
         begin
            dump_start = 1'b1;
            @(posedge clk); #1;
            dump_start = 1'b0;
         end
      join
      check("coll_busy_after_read", 32'(dump_busy), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (dump_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("coll_dump_started", 32'(seen), 32'd1);
      @(posedge clk); #1;
      push_dump_expect();
      mem_write = 1'b1;
      addr      = 32'd9;
      wdata     = 32'h999;
      @(negedge clk);
      check("coll_wr_stalled", 32'(stall), 32'd1);
      @(posedge clk); #1;
      run_dump(1'b0, hs);
      @(negedge clk);
      check("coll_wr_unstall", 32'(stall), 32'd0);
      check("coll_busy_end", 32'(dump_busy), 32'd0);
      @(posedge clk); #1;
      mem_write = 1'b0;
      op_read(32'd9, 32'h999, 1'b0);
      op_write(32'd10, 32'h1010, 1'b0, 1'b0);
      check("rdata_hold", rdata, 32'h999);

      // Reset during RD_WAIT
      mem_read = 1'b1;
      addr     = 32'd9;
      @(posedge clk); #3;
      rst      = 1'b0;
      mem_read = 1'b0;
      #1;
      check_all_zero("rst_rdwait");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      op_read(32'd9, 32'h999, 1'b0);

      // Reset during DUMP_OUT
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      dump_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (dump_valid && dump_addr == AW'(3)) begin
            seen = 1'b1;
            break;
         end
      end
      dump_ready = 1'b0;
      check("rst_dump_reached", 32'(seen), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("rst_dumpout");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_dump_idle", 32'(dump_busy), 32'd0);
      op_read(32'd2, 32'd102, 1'b0);
      op_read(32'd5, 32'd105, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
